// File: rtl/neg_seq.sv
// rtl/neg_seq.sv - multi-cycle two's-complement negator, CHUNK bits per cycle, LSB chunk first
// Optional absolute-value mode (in_abs port) enabled by defining NEG_SEQ_ABS_EN.
module neg_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_neg,
`ifdef NEG_SEQ_ABS_EN
    input  logic             in_abs,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int BW     = $clog2(WIDTH) + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDXW-1:0]  r_idx;
    logic             r_seen;
    logic             r_lowzero;
    logic             r_neg;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_out;
    logic             r_ovf;

    logic             w_neg_eff;
    logic             w_last;
    logic [BW-1:0]    w_base;
    logic [CHUNK-1:0] w_chunk;
    logic [CHUNK-1:0] w_chunk_lz;
    logic [CHUNK-1:0] w_res;
    logic             w_seen_nxt;
    logic             w_lowzero_nxt;
    logic             w_ovf;

`ifdef NEG_SEQ_ABS_EN
    assign w_neg_eff = in_abs ? in_data[WIDTH-1] : in_neg;
`else
    assign w_neg_eff = in_neg;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_out;
    assign out_ovf   = r_ovf;

    assign w_last  = (r_idx == LAST_IDX);
    assign w_base  = BW'(r_idx) * BW'(CHUNK);
    assign w_chunk = r_data[w_base +: CHUNK];

    // Bit j flips once any lower bit of the whole operand has been a one.
    always_comb begin : chunk_negate
        logic v_run;
        v_run = r_seen;
        w_res = '0;
        for (int j = 0; j < CHUNK; j++) begin
            w_res[j] = w_chunk[j] ^ (r_neg & v_run);
            v_run    = v_run | w_chunk[j];
        end
        w_seen_nxt = v_run;
    end

    // The sign bit is excluded from the "all lower bits zero" test on the top chunk.
    always_comb begin
        w_chunk_lz = w_chunk;
        if (w_last) begin
            w_chunk_lz[CHUNK-1] = 1'b0;
        end
        w_lowzero_nxt = r_lowzero & ~(|w_chunk_lz);
        w_ovf         = r_neg & w_chunk[CHUNK-1] & w_lowzero_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = BUSY;
            BUSY:    if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_seen    <= 1'b0;
            r_lowzero <= 1'b1;
            r_neg     <= 1'b0;
            r_data    <= '0;
            r_out     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data    <= in_data;
                        r_neg     <= w_neg_eff;
                        r_idx     <= '0;
                        r_seen    <= 1'b0;
                        r_lowzero <= 1'b1;
                    end
                end
                BUSY: begin
                    r_out[w_base +: CHUNK] <= w_res;
                    r_seen    <= w_seen_nxt;
                    r_lowzero <= w_lowzero_nxt;
                    r_idx     <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) begin
                        r_ovf <= w_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neg_seq.sv
// tb/tb_neg_seq.sv - directed self-checking bench for neg_seq (WIDTH=64, CHUNK=16)
// Absolute-value cases run only when NEG_SEQ_ABS_EN is defined.
module tb_neg_seq;

    localparam int WIDTH  = 64;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_neg;
    logic             in_abs;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    neg_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_neg    (in_neg),
`ifdef NEG_SEQ_ABS_EN
        .in_abs    (in_abs),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    // Offers one operand, scrambles the inputs after accept, waits (bounded) for out_valid.
    // lat = rising edges from accept to out_valid, or -1 on timeout.
    task automatic do_op(input logic [WIDTH-1:0] d, input logic n, input logic a,
                         output logic [WIDTH-1:0] r, output logic o, output int lat);
        int guard;
        @(negedge clk);
        in_data  = d;
        in_neg   = n;
        in_abs   = a;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_neg   = ~n;
        in_abs   = ~a;
        lat      = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = out_data;
        o = out_ovf;
        if (!out_valid || guard >= 50) lat = -1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_neg    = 1'b0;
        in_abs    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== '0)    begin n_bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        n_cmp++; if (out_ovf !== 1'b0)   begin n_bad++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_negate();
        logic [WIDTH-1:0] vd [7];
        logic             vn [7];
        logic [WIDTH-1:0] ve [7];
        logic             vo [7];
        logic [WIDTH-1:0] r;
        logic             o;
        int               lat;
        vd[0] = 64'h0000_0000_0000_0001; vn[0] = 1; ve[0] = 64'hFFFF_FFFF_FFFF_FFFF; vo[0] = 0;
        vd[1] = 64'h0000_0001_0000_0000; vn[1] = 1; ve[1] = 64'hFFFF_FFFF_0000_0000; vo[1] = 0;
        vd[2] = 64'h0000_0000_0000_0000; vn[2] = 1; ve[2] = 64'h0000_0000_0000_0000; vo[2] = 0;
        vd[3] = 64'h8000_0000_0000_0000; vn[3] = 1; ve[3] = 64'h8000_0000_0000_0000; vo[3] = 1;
        vd[4] = 64'h8000_0000_0000_0000; vn[4] = 0; ve[4] = 64'h8000_0000_0000_0000; vo[4] = 0;
        vd[5] = 64'hFFFF_FFFF_FFFF_FFFF; vn[5] = 1; ve[5] = 64'h0000_0000_0000_0001; vo[5] = 0;
        vd[6] = 64'h8000_0000_0001_0000; vn[6] = 1; ve[6] = 64'h7FFF_FFFF_FFFF_0000; vo[6] = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            do_op(vd[i], vn[i], 1'b0, r, o, lat);
            n_cmp++; if (lat !== NCHUNK) begin n_bad++; $display("FAIL neg%0d_latency got=%0d exp=%0d", i, lat, NCHUNK); end
            n_cmp++; if (r !== ve[i])    begin n_bad++; $display("FAIL neg%0d_data got=%h exp=%h", i, r, ve[i]); end
            n_cmp++; if (o !== vo[i])    begin n_bad++; $display("FAIL neg%0d_ovf got=%b exp=%b", i, o, vo[i]); end
            @(posedge clk);
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL neg%0d_idle_return got=%b exp=1", i, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] r;
        logic             o;
        int               lat;
        out_ready = 1'b0;
        do_op(64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, r, o, lat);
        n_cmp++; if (lat !== NCHUNK) begin n_bad++; $display("FAIL bp_latency got=%0d exp=%0d", lat, NCHUNK); end
        // A competing operand is offered while the result is held.
        in_valid = 1'b1;
        in_data  = 64'h0000_0000_0000_0002;
        in_neg   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid c=%0d got=%b exp=1", c, out_valid); end
            n_cmp++; if (out_data !== 64'hEDCB_A987_6543_2110) begin n_bad++; $display("FAIL bp_hold_data c=%0d got=%h exp=edcba98765432110", c, out_data); end
            n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL bp_hold_in_ready c=%0d got=%b exp=0", c, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
        do_op(64'h0000_0000_0000_0002, 1'b1, 1'b0, r, o, lat);
        n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_bad++; $display("FAIL bp_next_data got=%h exp=fffffffffffffffe", r); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_abort();
        logic [WIDTH-1:0] r;
        logic             o;
        int               lat;
        out_ready = 1'b1;
        @(negedge clk);
        in_data  = 64'h0000_0000_0000_0001;
        in_neg   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_data !== '0)    begin n_bad++; $display("FAIL abort_out_data got=%h exp=0", out_data); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(64'h0000_0000_0000_0003, 1'b1, 1'b0, r, o, lat);
        n_cmp++; if (lat !== NCHUNK) begin n_bad++; $display("FAIL abort_fresh_latency got=%0d exp=%0d", lat, NCHUNK); end
        n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_bad++; $display("FAIL abort_fresh_data got=%h exp=fffffffffffffffd", r); end
        @(posedge clk);
        #1;
    endtask

`ifdef NEG_SEQ_ABS_EN
    task automatic test_abs();
        logic [WIDTH-1:0] r;
        logic             o;
        int               lat;
        out_ready = 1'b1;
        do_op(64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b1, r, o, lat);
        n_cmp++; if (r !== 64'h5) begin n_bad++; $display("FAIL abs_neg_data got=%h exp=5", r); end
        @(posedge clk);
        #1;
        do_op(64'h7, 1'b1, 1'b1, r, o, lat);
        n_cmp++; if (r !== 64'h7) begin n_bad++; $display("FAIL abs_pos_data got=%h exp=7", r); end
        @(posedge clk);
        #1;
        do_op(64'h8000_0000_0000_0000, 1'b0, 1'b1, r, o, lat);
        n_cmp++; if (o !== 1'b1) begin n_bad++; $display("FAIL abs_ovf got=%b exp=1", o); end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_negate();
        test_backpressure();
        test_abort();
`ifdef NEG_SEQ_ABS_EN
        test_abs();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/neg_seq.md
Name: neg_seq

Overview:
Parametrised, multi-cycle two's-complement negator. It processes a WIDTH-bit operand CHUNK bits per cycle, LSB chunk first, and carries a "one seen below" flag between chunks.
It replaces the fixed 64-bit combinational complementer where the 63-level OR chain breaks timing. Typical users are the divider/multiplier sign-fix paths.
It uses a valid/ready handshake on both sides and flags overflow when negating the most-negative value.

Parameters:
WIDTH, 64, operand width in bits; must be a multiple of CHUNK.
CHUNK, 16, bits processed per BUSY cycle; NCHUNK = WIDTH/CHUNK; legal values 1..WIDTH.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand offered
in_ready  output  1  block can accept an operand
in_data  input  WIDTH  operand
in_neg  input  1  1 = negate, 0 = pass through unchanged
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
out_data  output  WIDTH  result
out_ovf  output  1  in_neg=1 and in_data = 1 followed by WIDTH-1 zeros

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, chunk index=0, seen=0, lowzero=1.
  - out_data=0, out_valid=0, out_ovf=0.
  - in_ready=1; the bench holds in_valid low during reset.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state.
- States and transitions:
  - IDLE: on in_valid, capture in_data and in_neg, set idx=0, seen=0, lowzero=1, go to BUSY.
  - BUSY: each cycle process chunk idx.
    - For bit j of the chunk: r[j] = d[j] XOR (neg AND (seen OR any d[k] for k<j within the chunk)).
    - Update seen |= OR(chunk). Update lowzero &= (chunk==0), where the MSB is excluded when idx=NCHUNK-1.
    - Write r into out_data chunk idx, then idx++.
    - After chunk NCHUNK-1 go to DONE.
  - DONE: out_data and out_ovf are held stable. On out_ready go to IDLE.
- out_ovf is computed on the final BUSY cycle as neg AND d[WIDTH-1] AND lowzero.
- Latency: the accept handshake happens on edge T0. out_valid rises after edge T0+NCHUNK, i.e. NCHUNK cycles in BUSY. With out_ready held high, IDLE is re-entered at T0+NCHUNK+1.
- Throughput: one operand per NCHUNK+2 cycles when there is no backpressure. in_ready is low in BUSY and DONE, so no operand is accepted during DONE.
- in_neg=0 takes the same fixed latency. The result equals the input and out_ovf=0.
- Arithmetic is modulo 2^WIDTH. Negating 0 gives 0 with out_ovf=0.
- out_data is undefined-but-stable (partially updated) during BUSY. Consumers use it only when out_valid=1.
- Reset asserted in BUSY or DONE aborts the operation and all state and outputs return to reset values. No result is delivered.
- in_data and in_neg are sampled only at the IDLE handshake; later changes have no effect.
- CHUNK=WIDTH is legal: BUSY lasts one cycle.

Optional Feature:
NEG_SEQ_ABS_EN
- Defined: adds input port in_abs (1 bit), sampled with in_data. When in_abs=1, the effective negate = in_data[WIDTH-1], i.e. absolute value, and in_neg is ignored. out_ovf is set for the most-negative input.
- Undefined: the port is absent and the effective negate = in_neg always.

Test Plan:
Assume WIDTH=64, CHUNK=16, so NCHUNK=4.
1. in_data=0x0000_0000_0000_0001, in_neg=1, out_ready=1 -> out_valid rises 4 cycles after accept; out_data=0xFFFF_FFFF_FFFF_FFFF; out_ovf=0.
2. in_data=0x0000_0001_0000_0000, in_neg=1 (tests the cross-chunk seen flag) -> out_data=0xFFFF_FFFF_0000_0000. in_data=0 -> out_data=0, out_ovf=0.
3. in_data=0x8000_0000_0000_0000, in_neg=1 -> out_data=0x8000_0000_0000_0000, out_ovf=1. Same input with in_neg=0 -> identical data, out_ovf=0.
4. in_data=0x1234_5678_9ABC_DEF0, in_neg=1, out_ready held low 10 cycles -> out_valid stays 1, out_data=0xEDCB_A987_6543_2110 stable, in_ready=0 throughout; the next operand is accepted only after IDLE is re-entered.
5. rst_n pulsed low during the 2nd BUSY cycle -> out_valid=0, in_ready=1, out_data=0 immediately (asynchronously). A fresh operand after release returns the correct result.
6. With NEG_SEQ_ABS_EN: in_abs=1, in_data=0xFFFF_FFFF_FFFF_FFFB -> out_data=0x5. in_abs=1, in_data=0x7 -> out_data=0x7.
